// File: rtl/stripes_pkg.sv
// rtl/stripes_pkg.sv - shared types, constants and helpers for the stripes transposer datapath
package stripes_pkg;

  localparam int SEL_BITS = 4;
  localparam int WL       = 2**SEL_BITS;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } seq_state_e;

  // A precision of zero, or one wider than the word, streams the full word.
  function automatic logic [SEL_BITS:0] clamp_prec(input logic [SEL_BITS:0] p);
    if (p == '0 || p > (SEL_BITS+1)'(WL)) begin
      return (SEL_BITS+1)'(WL);
    end
    return p;
  endfunction

endpackage

// File: rtl/transposer_sequencer.sv
// rtl/transposer_sequencer.sv - fills transposer slots with bricks, then steps them in lockstep through bit-serial readout
module transposer_sequencer
  import stripes_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int SEL_BITS   = stripes_pkg::SEL_BITS,
  parameter int WL         = 2**SEL_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_brick_valid,
  output logic                           o_brick_ready,
  input  logic                           i_brick_last,
  input  logic                           i_flush,
  input  logic [SEL_BITS:0]              i_precision,
  output logic [ARRAY_SIZE-1:0]          o_enable,
  output logic [SEL_BITS*ARRAY_SIZE-1:0] o_sel,
  output logic [ARRAY_SIZE-1:0]          o_slot_mask,
  output logic                           o_stream_valid,
  input  logic                           i_stream_ready,
  output logic                           o_stream_last,
  output logic                           o_busy
);

  localparam int CW = $clog2(ARRAY_SIZE + 1);

  seq_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [SEL_BITS-1:0]   bit_q;
  logic [SEL_BITS:0]     prec_q;
  logic [ARRAY_SIZE-1:0] mask_q;

  logic accept;
  logic fill_full;
  logic close_group;
  logic stream_last;
  logic stream_done;

  assign accept      = (state_q == FILL) & i_brick_valid;
  assign fill_full   = (cnt_q == CW'(ARRAY_SIZE - 1));
  // A flush alongside an accept still loads the brick; a flush on an empty group is a no-op.
  assign close_group = (state_q == FILL) &
                       ((accept & (i_brick_last | fill_full | i_flush)) |
                        (i_flush & (cnt_q != '0)));
  assign stream_last = (state_q == STREAM) & ({1'b0, bit_q} == (prec_q - 1'b1));
  assign stream_done = stream_last & i_stream_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (close_group) state_d = STREAM;
      STREAM:  if (stream_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    o_brick_ready  = 1'b0;
    o_enable       = '0;
    o_stream_valid = 1'b0;
    o_stream_last  = 1'b0;
    o_slot_mask    = mask_q;
    o_busy         = (state_q == STREAM) | (cnt_q != '0);
    o_sel          = {ARRAY_SIZE{bit_q}};
    case (state_q)
      FILL: begin
        o_brick_ready = 1'b1;
        if (accept) begin
          o_enable = {{(ARRAY_SIZE-1){1'b0}}, 1'b1} << cnt_q;
        end
      end
      STREAM: begin
        o_stream_valid = 1'b1;
        o_stream_last  = stream_last;
      end
      default: begin
        o_brick_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      prec_q <= '0;
      mask_q <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= cnt_q + 1'b1;
        mask_q <= mask_q | o_enable;
        if (cnt_q == '0) begin
          prec_q <= clamp_prec(i_precision);
        end
      end
      // Readout only advances on a consumed bit, so backpressure freezes o_sel.
      if ((state_q == STREAM) && i_stream_ready) begin
        if (stream_last) begin
          bit_q  <= '0;
          cnt_q  <= '0;
          mask_q <= '0;
        end else begin
          bit_q <= bit_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/transposer_sequencer.md
# transposer_sequencer

- Controls a `transposer_array`: fills up to ARRAY_SIZE transposer slots with bricks, then steps all loaded slots in lockstep through bit-serial readout.
- Loads use a valid/ready handshake.
- Readout honours downstream backpressure and a per-group precision of 1..WL bits.
- Sits between the brick fetch/buffer logic and the `transposer_array`; drives its `i_enable` and `i_sel` buses directly.

## Interface
- ARRAY_SIZE, 16, number of transposer slots.
- SEL_BITS, 4, bit-select width; WL = 2**SEL_BITS.
- WL, 16, word length in bits (max precision).
- clk  in  1  single clock; all flops on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_brick_valid  in  1  a brick is on the array data bus.
- o_brick_ready  out  1  sequencer can accept a brick this cycle.
- i_brick_last  in  1  qualifies the accepted brick as last of the group.
- i_flush  in  1  close the current partial group without a new brick.
- i_precision  in  SEL_BITS+1  bits to stream for the group; sampled on the group's first accept.
- o_enable  out  ARRAY_SIZE  one-hot load enable to `transposer_array.i_enable`.
- o_sel  out  SEL_BITS*ARRAY_SIZE  bit select, same value replicated per slot.
- o_slot_mask  out  ARRAY_SIZE  slots holding valid bricks in the current group.
- o_stream_valid  out  1  `transposer_array.o_stream` carries bit o_sel for the masked slots.
- i_stream_ready  in  1  downstream consumes the current bit.
- o_stream_last  out  1  current bit is the group's final bit.
- o_busy  out  1  a group is partially filled or streaming.

## Operation
- Two states: FILL and STREAM. Reset state is FILL.
- Load counter `cnt` (0..ARRAY_SIZE), bit counter `bit` (0..WL-1), latched precision `prec`.
- **FILL:**
  - o_brick_ready=1.
  - Accept = i_brick_valid & o_brick_ready.
  - On accept: o_enable = one-hot(cnt), combinational in the accept cycle. cnt increments. o_slot_mask bit cnt is set at the edge.
  - On accept with cnt==0: prec <= clamp(i_precision).
  - clamp: 0 or >WL maps to WL; otherwise the value as given.
  - Go to STREAM at the edge of an accept where i_brick_last=1 or cnt becomes ARRAY_SIZE.
  - Also go to STREAM on i_flush=1 with cnt>0.
  - i_flush with cnt==0 and no accept: ignored.
  - Flush in the same cycle as an accept: the brick is loaded, then the group closes.
- **STREAM:**
  - o_brick_ready=0, o_enable=0, o_stream_valid=1, o_sel=bit.
  - o_stream_last = (bit==prec-1).
  - On i_stream_ready=1: bit increments.
  - If o_stream_last: bit<=0, cnt<=0, o_slot_mask<=0, return to FILL.
  - i_stream_ready=0 holds o_sel and all outputs stable.
- Readout order is LSB first: bit index 0 first.
- Arithmetic: cnt is $clog2(ARRAY_SIZE+1) bits. prec is SEL_BITS+1 bits. bit compare is against prec-1, zero-extended.
- Reset at any point: all state cleared and the FILL state entered immediately. Transposer register contents are don't-care after reset.

## Timing
- Reset values:
  - o_brick_ready=1 once rst_n deasserts.
  - o_enable=0, o_sel=0, o_slot_mask=0.
  - o_stream_valid=0, o_stream_last=0, o_busy=0.
- o_enable and o_brick_ready are combinational from state/cnt and i_brick_valid. No other output depends combinationally on inputs.
- A brick accepted at edge N is in the transposer registers after edge N.
- If the group closes at edge N, o_stream_valid=1 in cycle N+1 with o_sel=0. Load-to-first-bit latency is 1 cycle.
- With i_stream_ready tied high, streaming takes exactly prec cycles. FILL is re-entered the cycle after the last bit.
- The earliest next accept is that same FILL cycle.
- o_busy = (state==STREAM) | (cnt>0).

## Structure
- Shared package `stripes_pkg`:
  - State enum {FILL, STREAM}.
  - Constants WL and SEL_BITS.
  - Function `clamp_prec`.
- Single flat module, no sub-modules.
- The optional one-hot decoder helper belongs in `stripes_pkg` as a function, not a module.

## Test plan
- **Full group:** 16 back-to-back bricks, i_precision=8, ready high.
  - o_enable walks 0x0001..0x8000 over 16 cycles; o_slot_mask=0xFFFF.
  - Then 8 stream cycles with o_sel 0..7 and last on sel=7.
  - FILL re-entered.
- **Partial via last:** 3 bricks, the third with i_brick_last=1, i_precision=16.
  - o_slot_mask=0x0007.
  - 16 stream bits; o_brick_ready=0 throughout.
- **Flush and ignored flush:** i_flush with cnt=0 → no state change. 2 bricks then i_flush alone → stream with mask 0x0003.
- **Backpressure:** during STREAM, i_stream_ready low for 5 cycles at sel=3 → o_sel stays 3 and o_stream_valid stays 1. Resuming completes the remaining bits in order.
- **Precision clamp:** i_precision=0 and i_precision=20 → 16 bits streamed. i_precision=1 → a single bit with o_stream_last=1.
- **Async reset mid-STREAM at sel=5:** rst_n low between edges → outputs are at reset values immediately. After release, a new brick loads into slot 0.
